// File: rtl/commit_trace_unit.sv
// Commit-trace producer: packs retirement events into 58-bit records, buffers them in a
// FIFO drained over valid/ready, and appends the summary counters once the core halts.
module commit_trace_unit #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [2:0]  reg_id,
  input  logic [15:0] reg_data,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        halt,
  input  logic        icache_req,
  input  logic        icache_hit,
  input  logic        dcache_req,
  input  logic        dcache_hit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [57:0] out_data,
  output logic        trace_stall,
  output logic        overflow,
  output logic        done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ZERO_CNT  = {CW{1'b0}};

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SUMMARY = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
    logic [CNT_W-1:0] result;
    if (en && (value != {CNT_W{1'b1}})) result = value + CNT_W'(1'b1);
    else result = value;
    return result;
  endfunction

  state_t           state_r;
  logic [2:0]       sum_idx_r;
  logic [CNT_W-1:0] cyc_r, inst_r, dhit_r, ihit_r, dreq_r, ireq_r;
  logic [57:0]      mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;

  logic             ev_s, pop_s, room_s, push_req_s, push_s, lost_s;
  logic [57:0]      ev_rec_s, sum_rec_s, push_rec_s, head_next_s;
  logic [CNT_W-1:0] sum_val_s;
  logic [CW-1:0]    count_popped_s, count_next_s;
  logic [AW-1:0]    rd_ptr_next_s;

  // Build the event record and the summary record for the current index.
  always_comb begin
    ev_s = halt | reg_wr | mem_rd | mem_wr;
    ev_rec_s = 58'd0;
    ev_rec_s[54:51] = {halt, reg_wr, mem_rd, mem_wr};
    if (reg_wr) begin
      ev_rec_s[50:48] = reg_id;
      ev_rec_s[47:32] = reg_data;
    end else begin
      ev_rec_s[50:32] = 19'd0;
    end
    if (mem_rd | mem_wr) begin
      ev_rec_s[31:16] = mem_addr;
      ev_rec_s[15:0]  = mem_rd ? mem_rdata : mem_wdata;
    end else begin
      ev_rec_s[31:0] = 32'd0;
    end
    case (sum_idx_r)
      3'd1:    sum_val_s = cyc_r;
      3'd2:    sum_val_s = inst_r;
      3'd3:    sum_val_s = dhit_r;
      3'd4:    sum_val_s = ihit_r;
      3'd5:    sum_val_s = dreq_r;
      3'd6:    sum_val_s = ireq_r;
      default: sum_val_s = {CNT_W{1'b0}};
    endcase
    sum_rec_s = {sum_idx_r, 23'd0, 32'(sum_val_s)};
  end

  // FIFO push/pop decisions and the next registered head value.
  always_comb begin
    push_req_s = 1'b0;
    push_rec_s = 58'd0;
    pop_s  = out_valid & out_ready;
    room_s = (count_r < FULL_CNT) | pop_s;
    case (state_r)
      RUN: begin
        push_req_s = ev_s;
        push_rec_s = ev_rec_s;
      end
      SUMMARY: begin
        push_req_s = 1'b1;
        push_rec_s = sum_rec_s;
      end
      default: begin
        push_req_s = 1'b0;
        push_rec_s = 58'd0;
      end
    endcase
    push_s = push_req_s & room_s;
    lost_s = (state_r == RUN) & ev_s & ~room_s;
    count_popped_s = count_r - CW'(pop_s);
    count_next_s   = count_popped_s + CW'(push_s);
    rd_ptr_next_s  = pop_s ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
    // A record written into an empty FIFO becomes the head on the same edge.
    if (count_next_s == ZERO_CNT) head_next_s = 58'd0;
    else if (count_popped_s == ZERO_CNT) head_next_s = push_rec_s;
    else head_next_s = mem_r[rd_ptr_next_s];
  end

  // FIFO storage; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (!rst && push_s) mem_r[wr_ptr_r] <= push_rec_s;
  end

  // Control FSM, counters, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      sum_idx_r   <= 3'd1;
      cyc_r       <= {CNT_W{1'b0}};
      inst_r      <= {CNT_W{1'b0}};
      dhit_r      <= {CNT_W{1'b0}};
      ihit_r      <= {CNT_W{1'b0}};
      dreq_r      <= {CNT_W{1'b0}};
      ireq_r      <= {CNT_W{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= ZERO_CNT;
      out_valid   <= 1'b0;
      out_data    <= 58'd0;
      trace_stall <= 1'b0;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      wr_ptr_r    <= push_s ? wr_ptr_r + AW'(1'b1) : wr_ptr_r;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      out_valid   <= (count_next_s != ZERO_CNT);
      out_data    <= head_next_s;
      trace_stall <= (count_next_s >= STALL_CNT);
      overflow    <= overflow | lost_s;
      case (state_r)
        RUN: begin
          cyc_r  <= sat_inc(cyc_r, 1'b1);
          inst_r <= sat_inc(inst_r, halt | reg_wr | mem_wr);
          dhit_r <= sat_inc(dhit_r, dcache_hit);
          ihit_r <= sat_inc(ihit_r, icache_hit);
          dreq_r <= sat_inc(dreq_r, dcache_req);
          ireq_r <= sat_inc(ireq_r, icache_req);
          if (halt) begin
            state_r   <= SUMMARY;
            sum_idx_r <= 3'd1;
          end
        end
        SUMMARY: begin
          if (push_s) begin
            if (sum_idx_r == 3'd6) state_r <= DONE;
            else sum_idx_r <= sum_idx_r + 3'd1;
          end
        end
        DONE: begin
          done <= done | (count_next_s == ZERO_CNT);
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_commit_trace_unit.sv
// Randomized bench for commit_trace_unit against a queue-based model of the trace stream.
module tb_commit_trace_unit;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam longint MAXC = (64'd1 << CNT_W) - 64'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wr;
  logic [2:0]  reg_id;
  logic [15:0] reg_data;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        halt;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;
  logic        out_valid, out_ready;
  logic [57:0] out_data;
  logic        trace_stall, overflow, done;

  int errors = 0;
  int checks = 0;

  // Model: expected record stream, counters indexed by summary type, phase 0=run, 1..6 summary, 7 done.
  logic [57:0] q[$];
  longint      m_cnt [1:6];
  int          m_phase = 0;
  bit          m_ovf = 1'b0;
  bit          m_done = 1'b0;

  commit_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_id(reg_id), .reg_data(reg_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .halt(halt), .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .trace_stall(trace_stall),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  function automatic longint bump(longint v, bit en);
    if (en && v < MAXC) return v + 1;
    return v;
  endfunction

  function automatic logic [57:0] mk_event();
    logic [2:0]  rid  = reg_wr ? reg_id : 3'd0;
    logic [15:0] rdat = reg_wr ? reg_data : 16'd0;
    logic [15:0] addr = (mem_rd || mem_wr) ? mem_addr : 16'd0;
    logic [15:0] md   = mem_rd ? mem_rdata : (mem_wr ? mem_wdata : 16'd0);
    return {3'd0, halt, reg_wr, mem_rd, mem_wr, rid, rdat, addr, md};
  endfunction

  task automatic set_idle();
    reg_wr = 1'b0; reg_id = 3'd0; reg_data = 16'd0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 16'd0; mem_wdata = 16'd0; mem_rdata = 16'd0;
    halt = 1'b0; icache_req = 1'b0; icache_hit = 1'b0; dcache_req = 1'b0; dcache_hit = 1'b0;
  endtask

  // Advance the model by one edge using the inputs now applied, then let the DUT clock.
  task automatic tick();
    bit pop, room, ev;
    if (rst) begin
      q.delete();
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_phase = 0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      pop  = (q.size() != 0) && (out_ready == 1'b1);
      room = (q.size() < DEPTH) || pop;
      if (pop) void'(q.pop_front());
      if (m_phase == 0) begin
        ev = halt || reg_wr || mem_rd || mem_wr;
        m_cnt[1] = bump(m_cnt[1], 1'b1);
        m_cnt[2] = bump(m_cnt[2], halt || reg_wr || mem_wr);
        m_cnt[3] = bump(m_cnt[3], dcache_hit);
        m_cnt[4] = bump(m_cnt[4], icache_hit);
        m_cnt[5] = bump(m_cnt[5], dcache_req);
        m_cnt[6] = bump(m_cnt[6], icache_req);
        if (ev && room) q.push_back(mk_event());
        else if (ev) m_ovf = 1'b1;
        if (halt) m_phase = 1;
      end else if (m_phase <= 6) begin
        if (room) begin
          q.push_back({3'(m_phase), 23'd0, 32'(m_cnt[m_phase])});
          m_phase++;
        end
      end
      if (m_phase == 7 && q.size() == 0) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_idle(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_idle(); out_ready = 1'b0;
    reg_wr = 1'b1; reg_id = 3'd7; reg_data = 16'hFFFF;
    repeat (2) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== 58'd0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
      checks++; if (trace_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", trace_stall); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    end
    rst = 1'b0; set_idle(); out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_push: got %b want 0", out_valid); end
    halt = 1'b1; tick(); set_idle();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (q.size() == 0 || out_valid !== 1'b1 || out_data !== q[0]) begin
        errors++; $display("FAIL reset_drain[%0d]: got v=%b %h", i, out_valid, out_data);
      end
      if (i == 1) begin
        checks++;
        if (out_data !== {3'd1, 23'd0, 32'd2}) begin
          errors++; $display("FAIL reset_cycle_count: got %h want cycles=2", out_data);
        end
      end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_done_after_drain: got %b want 1", done); end
  endtask

  task automatic test_single_write();
    do_reset(); out_ready = 1'b1;
    reg_wr = 1'b1; reg_id = 3'd3; reg_data = 16'h1234;
    mem_addr = 16'($urandom); mem_wdata = 16'($urandom); mem_rdata = 16'($urandom);
    tick(); set_idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++;
    if (out_data !== {3'd0, 4'b0100, 3'd3, 16'h1234, 32'd0}) begin
      errors++; $display("FAIL single_data: got %h want %h", out_data, {3'd0, 4'b0100, 3'd3, 16'h1234, 32'd0});
    end
    for (int i = 0; i < 12; i++) begin
      reg_wr = 1'($urandom); reg_id = 3'($urandom); reg_data = 16'($urandom);
      mem_rd = 1'($urandom); mem_wr = 1'($urandom); mem_addr = 16'($urandom);
      mem_wdata = 16'($urandom); mem_rdata = 16'($urandom);
      if (!(reg_wr || mem_rd || mem_wr)) mem_wr = 1'b1;
      tick();
      checks++;
      if (q.size() == 0 || out_valid !== 1'b1 || out_data !== q[0]) begin
        errors++; $display("FAIL pattern[%0d]: got v=%b %h", i, out_valid, out_data);
      end
    end
    set_idle();
  endtask

  task automatic test_load();
    logic [15:0] rd;
    do_reset(); out_ready = 1'b1;
    rd = 16'($urandom);
    reg_wr = 1'b1; mem_rd = 1'b1; reg_id = 3'd5; reg_data = rd;
    mem_addr = 16'h0040; mem_rdata = 16'hBEEF; mem_wdata = 16'($urandom);
    tick(); set_idle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== {3'd0, 4'b0110, 3'd5, rd, 16'h0040, 16'hBEEF}) begin
      errors++; $display("FAIL load_record: got v=%b %h want %h", out_valid, out_data,
                         {3'd0, 4'b0110, 3'd5, rd, 16'h0040, 16'hBEEF});
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_single: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [57:0] first;
    do_reset(); out_ready = 1'b0;
    first = 58'd0;
    for (int i = 1; i <= 9; i++) begin
      set_idle(); mem_wr = 1'b1; mem_addr = 16'($urandom); mem_wdata = 16'($urandom);
      tick();
      if (i == 1) first = q[0];
      checks++; if (trace_stall !== (i >= 7)) begin errors++; $display("FAIL bp_stall[%0d]: got %b want %b", i, trace_stall, (i >= 7)); end
      checks++; if (overflow !== (i >= 9)) begin errors++; $display("FAIL bp_overflow[%0d]: got %b want %b", i, overflow, (i >= 9)); end
      checks++; if (out_data !== first) begin errors++; $display("FAIL bp_head_stable[%0d]: got %h want %h", i, out_data, first); end
    end
    set_idle(); out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q.size() == 0 || out_valid !== 1'b1 || out_data !== q[0]) begin
        errors++; $display("FAIL bp_drain[%0d]: got v=%b %h", i, out_valid, out_data);
      end
      tick();
      checks++; if (trace_stall !== ((7 - i) >= 7)) begin errors++; $display("FAIL bp_stall_clear[%0d]: got %b", i, trace_stall); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    logic [57:0] exp_new;
    do_reset(); out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_idle(); mem_rd = 1'b1; reg_wr = 1'($urandom); reg_id = 3'($urandom);
      reg_data = 16'($urandom); mem_addr = 16'($urandom); mem_rdata = 16'($urandom);
      tick();
    end
    checks++; if (trace_stall !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL full_state: stall=%b ovf=%b want 1 0", trace_stall, overflow); end
    set_idle(); out_ready = 1'b1; reg_wr = 1'b1; reg_id = 3'($urandom); reg_data = 16'($urandom);
    exp_new = mk_event();
    tick(); set_idle();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_overflow: got %b want 0", overflow); end
    checks++; if (trace_stall !== 1'b1) begin errors++; $display("FAIL full_pop_count: stall %b want 1", trace_stall); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q.size() == 0 || out_valid !== 1'b1 || out_data !== q[0]) begin
        errors++; $display("FAIL full_drain[%0d]: got v=%b %h", i, out_valid, out_data);
      end
      if (i == 7) begin
        checks++; if (out_data !== exp_new) begin errors++; $display("FAIL full_new_last: got %h want %h", out_data, exp_new); end
      end
      tick();
    end
  endtask

  task automatic test_halt_summary();
    int vals[6] = '{10, 5, 0, 2, 0, 0};
    do_reset(); out_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      set_idle();
      if (c == 2 || c == 4 || c == 6 || c == 9) begin
        reg_wr = 1'b1; reg_id = 3'($urandom); reg_data = 16'($urandom);
      end
      if (c == 3 || c == 7) icache_hit = 1'b1;
      if (c == 10) halt = 1'b1;
      tick();
      if (q.size() != 0) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL halt_run[%0d]: got %h want %h", c, out_data, q[0]); end
      end
    end
    set_idle();
    checks++; if (out_valid !== 1'b1 || out_data !== {3'd0, 4'b1000, 51'd0}) begin errors++; $display("FAIL halt_record: got %h", out_data); end
    for (int t = 1; t <= 6; t++) begin
      reg_wr = 1'b1; icache_hit = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== {3'(t), 23'd0, 32'(vals[t-1])}) begin
        errors++; $display("FAIL summary_type%0d: got %h want %h", t, out_data, {3'(t), 23'd0, 32'(vals[t-1])});
      end
    end
    set_idle(); tick();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_done: done=%b valid=%b want 1 0", done, out_valid); end
    do_reset(); out_ready = 1'b0;
    reg_wr = 1'b1; reg_id = 3'd1; reg_data = 16'h00AA; tick();
    set_idle(); halt = 1'b1; tick(); set_idle();
    repeat (2) tick();
    rst = 1'b1; tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 58'd0 || trace_stall !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL summary_reset: v=%b d=%h s=%b o=%b dn=%b", out_valid, out_data, trace_stall, overflow, done);
    end
    rst = 1'b0; out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL summary_reset_run: got %b want 0", out_valid); end
    mem_wr = 1'b1; mem_addr = 16'h1000; mem_wdata = 16'h5A5A; tick(); set_idle();
    checks++; if (out_data !== {3'd0, 4'b0001, 19'd0, 16'h1000, 16'h5A5A}) begin errors++; $display("FAIL summary_reset_event: got %h", out_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      reg_wr = ($urandom_range(0, 2) == 0); reg_id = 3'($urandom); reg_data = 16'($urandom);
      mem_rd = ($urandom_range(0, 3) == 0); mem_wr = ($urandom_range(0, 3) == 0);
      mem_addr = 16'($urandom); mem_wdata = 16'($urandom); mem_rdata = 16'($urandom);
      icache_req = 1'($urandom); icache_hit = 1'($urandom);
      dcache_req = 1'($urandom); dcache_hit = 1'($urandom);
      halt = 1'b0; out_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b", n, out_valid); end
      if (q.size() != 0) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, out_data, q[0]); end
      end
      checks++; if (trace_stall !== (q.size() >= DEPTH - 1)) begin errors++; $display("FAIL rnd_stall[%0d]: got %b", n, trace_stall); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow[%0d]: got %b want %b", n, overflow, m_ovf); end
    end
    halt = 1'b1; tick(); set_idle(); out_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_sum_valid[%0d]: got %b", n, out_valid); end
      if (q.size() != 0) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rnd_sum_data[%0d]: got %h want %h", n, out_data, q[0]); end
      end
      tick();
    end
    checks++; if (done !== m_done || done !== 1'b1) begin errors++; $display("FAIL rnd_done: got %b want 1", done); end
  endtask

  initial begin
    rst = 1'b1; set_idle(); out_ready = 1'b0;
    test_reset();
    test_single_write();
    test_load();
    test_backpressure();
    test_full_pop();
    test_halt_summary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
